led_display_arbiter: RTL and testbench

- Shares the 8-digit seven-segment display driver between NREQ requesters, e.g. CPU MMIO store, PC/debug monitor, fault code.
- Grants one requester at a time, round-robin, and holds its value on the display for a minimum of HOLD_CYC cycles so it stays readable.
- Drives the driver's dig_en/wdata write port.
- Sits between the requesters and the display driver in the single-cycle CPU top level.

---
 rtl/led_display_pkg.sv | 14 +
 rtl/led_rr_picker.sv | 33 +++
 rtl/led_display_arbiter.sv | 126 ++++++++++++
 tb/tb_led_display_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Arbiter FSM states, display word width and the default hold time.
package led_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StHold
  } disp_state_e;

  localparam int unsigned DISP_W       = 32;
  localparam int unsigned HOLD_CYC_DEF = 25000000;

endpackage

// File: rtl/led_rr_picker.sv
// Combinational round-robin select: the first set req bit at or after ptr,
// ascending and wrapping at NREQ-1 -> 0.
module led_rr_picker #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned OWN_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [OWN_W-1:0] ptr,
  output logic             any,
  output logic [OWN_W-1:0] winner
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  int unsigned idx;

  // Scan offsets from farthest to nearest so the closest requester wins last.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + (NREQ - 1 - k);
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (req[idx[IdxW-1:0]]) begin
        winner = idx[OWN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin arbiter sharing the seven-segment display write port; each load is
// held for HOLD_CYC cycles. Define LED_DISPLAY_ARB_PREEMPT_EN to let requester 0 cut a hold short.
module led_display_arbiter
  import led_display_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned OWN_W    = 2,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [DISP_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     dig_en,
  output logic [DISP_W-1:0]        wdata,
  output logic [OWN_W-1:0]         owner,
  output logic                     busy
);

  disp_state_e       state_q, state_d;
  logic [OWN_W-1:0]  ptr_q, ptr_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              dig_en_q, dig_en_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DISP_W-1:0] wdata_q, wdata_d;

  logic              rr_any, preempt, grant, hold_done;
  logic [OWN_W-1:0]  rr_winner, grant_idx;
  logic [DISP_W-1:0] req_word [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign req_word[i] = req_data[DISP_W*i +: DISP_W];
  end

  led_rr_picker #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .any    (rr_any),
    .winner (rr_winner)
  );

`ifdef LED_DISPLAY_ARB_PREEMPT_EN
  assign preempt = (state_q == StHold) && req[0] && (owner_q != '0);
`else
  assign preempt = 1'b0;
`endif

  assign hold_done = (cnt_q == HOLD_CYC - 1);
  assign grant     = ((state_q == StIdle) && rr_any) || preempt;
  assign grant_idx = preempt ? '0 : rr_winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      dig_en_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      dig_en_q <= dig_en_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (grant) state_d = StLoad;
      end
      StLoad: begin
        state_d = StHold;
        cnt_d   = '0;
        ptr_d   = (owner_q == OWN_W'(NREQ - 1)) ? '0 : owner_q + OWN_W'(1);
      end
      StHold: begin
        if (preempt) begin
          state_d = StLoad;
        end else if (hold_done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output registers load on the edge entering LOAD, so they line up with that state.
  always_comb begin
    dig_en_d = grant;
    busy_d   = (state_d != StIdle);
    ack_d    = '0;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    if (grant) begin
      ack_d[grant_idx] = 1'b1;
      wdata_d          = req_word[grant_idx];
      owner_d          = grant_idx;
    end
  end

  assign ack    = ack_q;
  assign dig_en = dig_en_q;
  assign wdata  = wdata_q;
  assign owner  = owner_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed testbench for led_display_arbiter with NREQ=3, HOLD_CYC=4.
module tb_led_display_arbiter;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned OWN_W    = 2;
  localparam int unsigned HOLD_CYC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [95:0] req_data;
  logic [2:0]  ack;
  logic        dig_en;
  logic [31:0] wdata;
  logic [1:0]  owner;
  logic        busy;

  int checks = 0;
  int errors = 0;

  led_display_arbiter #(
    .NREQ     (NREQ),
    .OWN_W    (OWN_W),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .dig_en   (dig_en),
    .wdata    (wdata),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = 3'b111;
    req_data = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({dig_en, ack, wdata, owner, busy} !== 39'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got en=%b ack=%b wdata=%h owner=%0d busy=%b expected all zero",
                 i, dig_en, ack, wdata, owner, busy);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (dig_en !== 1'b1 || ack !== 3'b001 || owner !== 2'd0 || wdata !== 32'h1) begin
      errors++;
      $display("FAIL reset_first_grant: got en=%b ack=%b owner=%0d wdata=%h expected 1 001 0 00000001",
               dig_en, ack, owner, wdata);
    end
    req = 3'b000;
    repeat (HOLD_CYC + 1) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_back_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req      = 3'b010;
    req_data = {32'h0, 32'h1234_ABCD, 32'h0};
    step();
    checks++;
    if (dig_en !== 1'b1 || ack !== 3'b010 || wdata !== 32'h1234_ABCD || owner !== 2'd1
        || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_load: got en=%b ack=%b wdata=%h owner=%0d busy=%b expected 1 010 1234abcd 1 1",
               dig_en, ack, wdata, owner, busy);
    end
    req      = 3'b000;
    req_data = {32'h0, 32'h5555_5555, 32'h0};
    for (int i = 0; i < HOLD_CYC; i++) begin
      step();
      checks++;
      if (busy !== 1'b1 || dig_en !== 1'b0 || ack !== 3'b000) begin
        errors++;
        $display("FAIL single_hold %0d: got busy=%b en=%b ack=%b expected 1 0 000",
                 i, busy, dig_en, ack);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || dig_en !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b en=%b expected 0 0", busy, dig_en);
    end
    checks++;
    if (wdata !== 32'h1234_ABCD || owner !== 2'd1) begin
      errors++;
      $display("FAIL single_retain: got wdata=%h owner=%0d expected 1234abcd 1", wdata, owner);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_ack [4];
    int         last;
    int         n;
    exp_ack[0] = 3'b001;
    exp_ack[1] = 3'b010;
    exp_ack[2] = 3'b100;
    exp_ack[3] = 3'b001;
    last = 0;
    n    = 0;
    do_reset();
    req      = 3'b111;
    req_data = {32'hC, 32'hB, 32'hA};
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      step();
      req = 3'b111;
      if (dig_en === 1'b1) begin
        checks++;
        if (ack !== exp_ack[n]) begin
          errors++;
          $display("FAIL fair_order %0d: got ack=%b expected %b", n, ack, exp_ack[n]);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last !== 6) begin
            errors++;
            $display("FAIL fair_spacing %0d: got %0d cycles expected 6", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        req = 3'b111 & ~ack;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL fair_count: got %0d grants expected 4", n);
    end
    req = 3'b000;
  endtask

  task automatic test_missed();
    do_reset();
    req      = 3'b001;
    req_data = {32'h2222_2222, 32'h0, 32'h1111_1111};
    step();
    checks++;
    if (ack !== 3'b001) begin
      errors++;
      $display("FAIL missed_first_ack: got %b expected 001", ack);
    end
    req = 3'b000;
    step();
    req = 3'b100;
    step();
    step();
    step();
    req = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (dig_en !== 1'b0 || ack !== 3'b000) begin
        errors++;
        $display("FAIL missed_no_grant %0d: got en=%b ack=%b expected 0 000", i, dig_en, ack);
      end
    end
    checks++;
    if (busy !== 1'b0 || wdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL missed_idle: got busy=%b wdata=%h expected 0 11111111", busy, wdata);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req      = 3'b010;
    req_data = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    step();
    req = 3'b000;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({dig_en, ack, wdata, owner, busy} !== 39'd0) begin
      errors++;
      $display("FAIL midhold_reset: got en=%b ack=%b wdata=%h owner=%0d busy=%b expected all zero",
               dig_en, ack, wdata, owner, busy);
    end
    rst = 1'b0;
    req = 3'b110;
    step();
    checks++;
    if (ack !== 3'b010 || owner !== 2'd1 || wdata !== 32'h3333_0001) begin
      errors++;
      $display("FAIL midhold_ptr: got ack=%b owner=%0d wdata=%h expected 010 1 33330001",
               ack, owner, wdata);
    end
    req = 3'b000;
    repeat (HOLD_CYC + 1) step();
  endtask

  task automatic test_preempt();
    do_reset();
    req      = 3'b100;
    req_data = {32'h0000_00C2, 32'h0, 32'h0};
    step();
    checks++;
    if (owner !== 2'd2 || ack !== 3'b100) begin
      errors++;
      $display("FAIL preempt_setup: got owner=%0d ack=%b expected 2 100", owner, ack);
    end
    req = 3'b000;
    step();
    step();
    req      = 3'b001;
    req_data = {32'h0, 32'h0, 32'hDEAD_0001};
`ifdef LED_DISPLAY_ARB_PREEMPT_EN
    step();
    checks++;
    if (dig_en !== 1'b1 || ack !== 3'b001 || wdata !== 32'hDEAD_0001) begin
      errors++;
      $display("FAIL preempt_load: got en=%b ack=%b wdata=%h expected 1 001 dead0001",
               dig_en, ack, wdata);
    end
`else
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dig_en !== 1'b0) begin
        errors++;
        $display("FAIL preempt_off_early %0d: got en=%b expected 0", i, dig_en);
      end
    end
    step();
    checks++;
    if (dig_en !== 1'b1 || ack !== 3'b001 || wdata !== 32'hDEAD_0001) begin
      errors++;
      $display("FAIL preempt_off_load: got en=%b ack=%b wdata=%h expected 1 001 dead0001",
               dig_en, ack, wdata);
    end
`endif
    req = 3'b000;
    repeat (HOLD_CYC + 2) step();
  endtask

  initial begin
    rst      = 1'b1;
    req      = 3'b000;
    req_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_missed();
    test_reset_mid_hold();
    test_preempt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
